// File: rtl/hazard_pkg.sv
// Shared sizing and helpers for the register scoreboard hazard controller.
package hazard_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  // A register is still pending unless its last writer retires in WB this very
  // cycle; the register file writes before ID samples, so that value is usable.
  function automatic logic is_pending(input logic [CNT_W-1:0] cnt, input logic wb_hit);
    return (cnt != '0) && !(wb_hit && (cnt == CNT_W'(1)));
  endfunction

endpackage

// File: rtl/pending_counter.sv
// Per-register in-flight writer counter: up on issue, down on WB retire.
module pending_counter
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dec_eff;

  // Next count; a retire with nothing pending is only an error if no writer
  // is being issued to the same register in this cycle.
  always_comb begin
    dec_eff   = dec && (cnt_q != '0);
    underflow = dec && (cnt_q == '0) && !inc;
    cnt_d     = cnt_q;
    if (inc && !dec_eff && (cnt_q != CNT_W'(CNT_MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_eff && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign nonzero = |cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: raises the ID-stage hazard while a source operand has
// an in-flight writer or the destination's writer count is saturated.
// Optional macro HAZARD_STATS_EN adds stall_cycles and issue_count outputs.
module reg_scoreboard
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_src1,
  input  logic [REG_W-1:0]    id_src2,
  input  logic                id_two_src,
  input  logic                id_wb_en,
  input  logic [REG_W-1:0]    id_dest,
  input  logic                wb_en,
  input  logic [REG_W-1:0]    wb_dest,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                err_underflow
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         issue_count
`endif
);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] uf_vec;
  logic                src1_pend;
  logic                src2_pend;
  logic                sat_hit;
  logic                issue;
  logic                err_q;

  // Operand and saturation hazard, evaluated in the same cycle ID presents.
  always_comb begin
    src1_pend = is_pending(cnt[id_src1], wb_en && (wb_dest == id_src1));
    src2_pend = is_pending(cnt[id_src2], wb_en && (wb_dest == id_src2));
    // A same-cycle retire of id_dest frees a slot, so the new writer may go.
    sat_hit   = id_wb_en && (cnt[id_dest] == CNT_W'(CNT_MAX)) &&
                !(wb_en && (wb_dest == id_dest));
    hazard    = id_valid && (src1_pend || (id_two_src && src2_pend) || sat_hit);
    issue     = id_valid && !hazard && !freeze;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    assign inc_vec[i] = issue && id_wb_en && (id_dest == REG_W'(i));
    assign dec_vec[i] = wb_en && (wb_dest == REG_W'(i));

    pending_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_vec[i]),
      .dec       (dec_vec[i]),
      .cnt       (cnt[i]),
      .nonzero   (busy_vec[i]),
      .underflow (uf_vec[i])
    );
  end

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|uf_vec) begin
      err_q <= 1'b1;
    end
  end

  assign err_underflow = err_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] issue_q;

  // Free-running statistics, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      issue_q <= '0;
    end else begin
      if (hazard && !freeze) stall_q <= stall_q + 32'd1;
      if (issue)             issue_q <= issue_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign issue_count  = issue_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized scoreboard bench for reg_scoreboard with a behavioural model.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        id_valid;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic        id_wb_en;
  logic [3:0]  id_dest;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic        hazard;
  logic [15:0] busy_vec;
  logic        err_underflow;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] issue_count;
`endif

  reg_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .id_valid      (id_valid),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_two_src    (id_two_src),
    .id_wb_en      (id_wb_en),
    .id_dest       (id_dest),
    .wb_en         (wb_en),
    .wb_dest       (wb_dest),
    .hazard        (hazard),
    .busy_vec      (busy_vec),
    .err_underflow (err_underflow)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .issue_count   (issue_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cyc;
    bit          hz;
    logic [15:0] busy;
    bit          err;
    int unsigned stall;
    int unsigned iss;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Reference model state: in-flight writer count per register.
  int unsigned mcnt[16];
  bit          merr;
  int unsigned mstall;
  int unsigned missue;

  function automatic bit mpend(input int r, input bit wbe, input int wd);
    if (mcnt[r] == 0) return 1'b0;
    if (wbe && wd == r && mcnt[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, c, got, want);
    end
  endtask

  // Drive one cycle, push the expected view of that cycle, advance the model.
  task automatic step(input bit r, input bit fz, input bit v, input int s1, input int s2,
                      input bit two, input bit iwb, input int d, input bit wbe, input int wd);
    exp_t e;
    bit   hz;
    bit   iss;
    int   delta[16];
    rst        = r;
    freeze     = fz;
    id_valid   = v;
    id_src1    = 4'(s1);
    id_src2    = 4'(s2);
    id_two_src = two;
    id_wb_en   = iwb;
    id_dest    = 4'(d);
    wb_en      = wbe;
    wb_dest    = 4'(wd);

    hz = v && (mpend(s1, wbe, wd) || (two && mpend(s2, wbe, wd)) ||
               (iwb && mcnt[d] == 3 && !(wbe && wd == d)));
    iss = v && !hz && !fz;

    e.cyc = cyc;
    e.hz  = hz;
    for (int i = 0; i < 16; i++) e.busy[i] = (mcnt[i] != 0);
    e.err   = merr;
    e.stall = mstall;
    e.iss   = missue;
    exp_q.push_back(e);

    if (r) begin
      for (int i = 0; i < 16; i++) mcnt[i] = 0;
      merr   = 1'b0;
      mstall = 0;
      missue = 0;
    end else begin
      for (int i = 0; i < 16; i++) delta[i] = 0;
      if (iss && iwb) delta[d] += 1;
      if (wbe) begin
        if (mcnt[wd] != 0) delta[wd] -= 1;
        else if (!(iss && iwb && d == wd)) merr = 1'b1;
      end
      for (int i = 0; i < 16; i++) mcnt[i] = 32'(int'(mcnt[i]) + delta[i]);
      if (hz && !fz) mstall++;
      if (iss) missue++;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue_wr(input int d);
    step(0, 0, 1, 0, 0, 0, 1, d, 0, 0);
  endtask

  task automatic wb(input int d);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, d);
  endtask

  // Monitor: compare the DUT against queued expectations mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hazard", e.cyc, 32'(hazard), 32'(e.hz));
        chk("busy_vec", e.cyc, 32'(busy_vec), 32'(e.busy));
        chk("err_underflow", e.cyc, 32'(err_underflow), 32'(e.err));
`ifdef HAZARD_STATS_EN
        chk("stall_cycles", e.cyc, stall_cycles, e.stall);
        chk("issue_count", e.cyc, issue_count, e.iss);
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
    merr   = 1'b0;
    mstall = 0;
    missue = 0;
    rst = 1'b1; freeze = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0;
    id_two_src = 1'b0; id_wb_en = 1'b0; id_dest = '0; wb_en = 1'b0; wb_dest = '0;
    @(posedge clk);
    #1;

    // Writer to R3, dependent reader stalls until WB bypass.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue_wr(3);
    step(0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0, 0, 1, 3);
    idle();

    // Second source only matters when it is read.
    issue_wr(5);
    step(0, 0, 1, 0, 5, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    wb(5);

    // Saturate R7, then a fourth writer with and without a same-cycle retire.
    issue_wr(7);
    issue_wr(7);
    issue_wr(7);
    issue_wr(7);
    step(0, 0, 1, 0, 0, 0, 1, 7, 1, 7);
    idle();
    wb(7);
    wb(7);
    wb(7);
    idle();

    // Frozen issue is not counted; released issue is.
    repeat (4) step(0, 1, 1, 0, 0, 0, 1, 2, 0, 0);
    issue_wr(2);
    idle();
    wb(2);

    // Underflow on R9 is sticky until reset.
    wb(9);
    idle();
    issue_wr(4);
    wb(4);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Stalls and issues for the statistics counters.
    issue_wr(6);
    repeat (5) step(0, 0, 1, 6, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 6, 0, 0, 1, 1, 1, 6);
    issue_wr(8);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Randomized traffic over a small register window to provoke hazards.
    repeat (3000) begin
      step($urandom_range(99) == 0, $urandom_range(7) == 0, $urandom_range(7) != 0,
           $urandom_range(7), $urandom_range(7), 1'($urandom), $urandom_range(3) != 0,
           $urandom_range(7), $urandom_range(1) == 0, $urandom_range(7));
    end
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Pipeline hazard controller that produces the ID stage `hazard` input.
Keeps a per-register count of in-flight writers. The count is incremented when an instruction with write-back leaves ID, and decremented when the WB stage writes that register.
Stalls ID (zeroes its control signals) while a source operand still has a pending writer. Also stalls on counter saturation.
Sits between the ID stage, the WB stage and the pipeline freeze logic. No forwarding path is assumed.

Parameters:
NUM_REGS, 16, number of architectural registers tracked
REG_W, 4, register index width
CNT_W, 2, width of each pending counter (max 3 in-flight writers per register)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  pipeline frozen (memory stall); no issue is counted this cycle
id_valid  in  1  ID holds a real instruction (0 for a bubble)
id_src1  in  REG_W  first source register (Rn)
id_src2  in  REG_W  second source register (Rm, or Rd for stores)
id_two_src  in  1  src2 is read by the instruction
id_wb_en  in  1  ID instruction writes a register (pre-gating control-unit value, condition passed)
id_dest  in  REG_W  ID destination register
wb_en  in  1  WB stage writes the register file this cycle
wb_dest  in  REG_W  WB destination register
hazard  out  1  stall ID this cycle
busy_vec  out  NUM_REGS  bit i = register i has a non-zero pending count
err_underflow  out  1  sticky: WB write to a register with count 0

Behaviour:
- Reset (rst=1 at a rising edge):
  - all counters = 0, busy_vec = 0, err_underflow = 0.
  - hazard is combinational, so it reads 0 after reset unless the inputs cause a stall.
- Operand hazard is combinational, in the same cycle. It is raised when id_valid and either:
  - pend(id_src1), or
  - id_two_src and pend(id_src2).
- pend(r) = (cnt[r] != 0), except that it is 0 when wb_en && wb_dest==r && cnt[r]==1.
  - This is the WB bypass: the register file writes before ID samples the value.
- Saturation hazard: hazard is also raised when id_valid && id_wb_en && cnt[id_dest] == 2^CNT_W-1 and no same-cycle WB decrement of id_dest.
- issue = id_valid && !hazard && !freeze.
  - Increment condition: issue && id_wb_en.
- Next-state per register r, applied at the rising edge:
  - increment only: cnt+1
  - decrement only (wb_en && wb_dest==r && cnt!=0): cnt-1
  - both increment and decrement: unchanged
  - neither: unchanged
- WB to a register with cnt==0 and no same-cycle increment: counter stays 0 and err_underflow is set.
  - err_underflow clears only on rst.
- freeze=1: no increments. WB decrements still apply. hazard is still computed and driven.
- Conditional instructions whose condition fails arrive with id_wb_en=0 and are not counted.
- busy_vec is registered: it reflects the counters after the edge (latency 1).
- Reset asserted mid-operation clears all pending state. In-flight WB writes after reset are then reported as underflow. The pipeline must be reset together with this block.

Optional Feature:
Macro: HAZARD_STATS_EN
- Defined:
  - adds output stall_cycles (32 bits): increments each cycle hazard=1 && !freeze.
  - adds output issue_count (32 bits): increments each issue.
  - both reset to 0 and wrap modulo 2^32.
- Not defined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- Package hazard_pkg: NUM_REGS, REG_W, CNT_W, and localparam CNT_MAX = 2^CNT_W-1.
- Sub-module pending_counter: one saturating up/down counter per register.
  - inputs: inc, dec
  - outputs: cnt, nonzero, underflow pulse
  - instantiated NUM_REGS times with a generate loop.
- Top level holds the hazard compare, the issue logic and the sticky error.

Test Plan:
1. Reset, then issue ADD with dest R3 (wb_en=1, id_valid=1). Next cycle ID reads src1=R3 -> hazard=1, busy_vec[3]=1. Stays 1 until WB asserts wb_dest=3; in that cycle hazard=0 (bypass), and next cycle busy_vec[3]=0.
2. id_two_src=0, id_src2=R5, R5 pending -> hazard=0. Same stimulus with id_two_src=1 -> hazard=1.
3. Issue three writers to R7 back-to-back (cnt=3). A fourth writer to R7 -> hazard=1. Same cycle with wb_en, wb_dest=7 -> hazard=0, and cnt stays 3 after the edge.
4. freeze=1 while issuing dest R2 for 4 cycles -> busy_vec[2] stays 0. Release freeze -> busy_vec[2]=1 after one edge.
5. wb_en=1, wb_dest=9 with cnt[9]=0 -> err_underflow=1 and remains 1 until rst; cnt[9] stays 0.
6. HAZARD_STATS_EN defined: 5 stall cycles and 3 issues -> stall_cycles=5, issue_count=3. Assert rst -> both read 0.
